// File: rtl/slavecontroller_pkg.sv
// Shared constants for the USB device-side transaction sequencer: PID codes,
// RXStatus error bit positions, transType codes and the FSM state type.
package slavecontroller_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam int SC_CRC_ERROR_BIT       = 0;
    localparam int SC_BIT_STUFF_ERROR_BIT = 1;
    localparam int SC_RX_OVERFLOW_BIT     = 2;
    localparam int SC_RX_TIME_OUT_BIT     = 3;

    localparam logic [1:0] SC_SETUP    = 2'd0;
    localparam logic [1:0] SC_IN       = 2'd1;
    localparam logic [1:0] SC_OUTDATA0 = 2'd2;
    localparam logic [1:0] SC_OUTDATA1 = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_WAIT_TOKEN,
        ST_CHK_TOKEN,
        ST_CHK_EP,
        ST_IN_SEL,
        ST_HS_SEND,
        ST_CLR_WEN,
        ST_WAIT_SENT,
        ST_IN_WAIT_ACK,
        ST_RX_REQ,
        ST_RX_WAIT_DATA,
        ST_RX_CHK
    } sc_state_t;

    function automatic logic rx_error(input logic [7:0] status);
        return status[SC_CRC_ERROR_BIT] | status[SC_BIT_STUFF_ERROR_BIT] |
               status[SC_RX_OVERFLOW_BIT] | status[SC_RX_TIME_OUT_BIT];
    endfunction

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/slavecontroller.sv
// USB device-side transaction sequencer: answers tokens addressed to this
// device with data or handshakes and reports completed transactions.
module slavecontroller
    import slavecontroller_pkg::*;
#(
    parameter int NUM_ENDPOINTS = 4,
    parameter int ENDP_SEL_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCGlobalEn,
    input  logic [6:0]            USBAddress,
    output logic                  getPacketREn,
    input  logic                  getPacketRdy,
    input  logic [3:0]            RXPacketPID,
    input  logic [6:0]            RXAddr,
    input  logic [3:0]            RXEndP,
    input  logic [7:0]            RXStatus,
    output logic                  sendPacketWEn,
    output logic [3:0]            sendPacketPID,
    input  logic                  sendPacketRdy,
    output logic [ENDP_SEL_W-1:0] endPointSel,
    input  logic                  EPEnable,
    input  logic                  EPReady,
    input  logic                  EPStall,
    input  logic                  EPDataSeq,
    output logic                  transDone,
    output logic                  clrEPRdy,
    output logic                  toggleDataSeq,
    output logic [1:0]            transType
);

    localparam logic [4:0] NUM_EP = 5'(NUM_ENDPOINTS);

    sc_state_t  state;
    logic [3:0] tok_pid;
    logic [3:0] hs_pid;
    logic [3:0] in_reply;
    logic       rx_err;
    logic       token_ok;
    logic       rx_seq;

    assign rx_err   = rx_error(RXStatus);
    assign rx_seq   = (RXPacketPID == PID_DATA1);
    assign token_ok = !rx_err &&
                      (RXPacketPID == PID_IN || RXPacketPID == PID_OUT || RXPacketPID == PID_SETUP) &&
                      (RXAddr == USBAddress) && ({1'b0, RXEndP} < NUM_EP);

    always_comb begin
        in_reply = EPDataSeq ? PID_DATA1 : PID_DATA0;
        if (EPStall)
            in_reply = PID_STALL;
        else if (!EPReady)
            in_reply = PID_NAK;
    end

    // Ready-wait states ignore the cycle in which their own request pulse is
    // still high, since the peer's ready has not dropped yet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            tok_pid       <= '0;
            hs_pid        <= '0;
            getPacketREn  <= 1'b0;
            sendPacketWEn <= 1'b0;
            sendPacketPID <= '0;
            endPointSel   <= '0;
            transDone     <= 1'b0;
            clrEPRdy      <= 1'b0;
            toggleDataSeq <= 1'b0;
            transType     <= '0;
        end else begin
            getPacketREn  <= 1'b0;
            sendPacketWEn <= 1'b0;
            transDone     <= 1'b0;
            clrEPRdy      <= 1'b0;
            toggleDataSeq <= 1'b0;
            case (state)
                ST_IDLE:
                    if (SCGlobalEn) state <= ST_WAIT_RDY;
                ST_WAIT_RDY:
                    if (!SCGlobalEn) begin
                        state <= ST_IDLE;
                    end else if (getPacketRdy) begin
                        getPacketREn <= 1'b1;
                        state        <= ST_WAIT_TOKEN;
                    end
                ST_WAIT_TOKEN:
                    if (!getPacketREn && getPacketRdy) state <= ST_CHK_TOKEN;
                ST_CHK_TOKEN:
                    if (token_ok) begin
                        endPointSel <= RXEndP[ENDP_SEL_W-1:0];
                        tok_pid     <= RXPacketPID;
                        state       <= ST_CHK_EP;
                    end else begin
                        state <= ST_WAIT_RDY;
                    end
                ST_CHK_EP:
                    if (!EPEnable)
                        state <= ST_WAIT_RDY;
                    else if (tok_pid == PID_IN)
                        state <= ST_IN_SEL;
                    else
                        state <= ST_RX_REQ;
                ST_IN_SEL:
                    if (sendPacketRdy) begin
                        sendPacketWEn <= 1'b1;
                        sendPacketPID <= in_reply;
                        state         <= ST_CLR_WEN;
                    end
                ST_HS_SEND:
                    if (sendPacketRdy) begin
                        sendPacketWEn <= 1'b1;
                        sendPacketPID <= hs_pid;
                        state         <= ST_CLR_WEN;
                    end
                ST_CLR_WEN:
                    state <= ST_WAIT_SENT;
                ST_WAIT_SENT:
                    if (sendPacketRdy) begin
                        if (is_data_pid(sendPacketPID)) begin
                            getPacketREn <= 1'b1;
                            state        <= ST_IN_WAIT_ACK;
                        end else begin
                            state <= ST_WAIT_RDY;
                        end
                    end
                ST_IN_WAIT_ACK:
                    if (!getPacketREn && getPacketRdy) begin
                        if (RXPacketPID == PID_ACK && !rx_err) begin
                            transDone     <= 1'b1;
                            clrEPRdy      <= 1'b1;
                            toggleDataSeq <= 1'b1;
                            transType     <= SC_IN;
                        end
                        state <= ST_WAIT_RDY;
                    end
                ST_RX_REQ: begin
                    getPacketREn <= 1'b1;
                    state        <= ST_RX_WAIT_DATA;
                end
                ST_RX_WAIT_DATA:
                    if (!getPacketREn && getPacketRdy) state <= ST_RX_CHK;
                // Handshake PID is latched here because the endpoint toggle
                // may flip before the handshake actually goes out.
                ST_RX_CHK:
                    if (rx_err || !is_data_pid(RXPacketPID)) begin
                        state <= ST_WAIT_RDY;
                    end else begin
                        state  <= ST_HS_SEND;
                        hs_pid <= PID_ACK;
                        if (tok_pid == PID_SETUP) begin
                            transDone     <= 1'b1;
                            clrEPRdy      <= 1'b1;
                            toggleDataSeq <= !EPDataSeq;
                            transType     <= SC_SETUP;
                        end else if (EPStall) begin
                            hs_pid <= PID_STALL;
                        end else if (!EPReady) begin
                            hs_pid <= PID_NAK;
                        end else if (rx_seq == EPDataSeq) begin
                            transDone     <= 1'b1;
                            clrEPRdy      <= 1'b1;
                            toggleDataSeq <= 1'b1;
                            transType     <= rx_seq ? SC_OUTDATA1 : SC_OUTDATA0;
                        end
                    end
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slavecontroller.sv
// Bench for slavecontroller: emulated receiver, transmitter and endpoint file
// with a transaction-level model feeding expectation queues.
`timescale 1ns/1ps
module tb_slavecontroller;
    import slavecontroller_pkg::*;

    localparam logic [6:0] DEV = 7'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCGlobalEn = 1'b0;
    logic [6:0] USBAddress = DEV;
    logic       getPacketREn;
    logic       getPacketRdy;
    logic [3:0] RXPacketPID;
    logic [6:0] RXAddr;
    logic [3:0] RXEndP;
    logic [7:0] RXStatus;
    logic       sendPacketWEn;
    logic [3:0] sendPacketPID;
    logic       sendPacketRdy;
    logic [1:0] endPointSel;
    logic       EPEnable, EPReady, EPStall, EPDataSeq;
    logic       transDone, clrEPRdy, toggleDataSeq;
    logic [1:0] transType;

    always #5 clk = ~clk;

    slavecontroller #(.NUM_ENDPOINTS(4), .ENDP_SEL_W(2)) dut (
        .clk(clk), .rst(rst), .SCGlobalEn(SCGlobalEn), .USBAddress(USBAddress),
        .getPacketREn(getPacketREn), .getPacketRdy(getPacketRdy),
        .RXPacketPID(RXPacketPID), .RXAddr(RXAddr), .RXEndP(RXEndP), .RXStatus(RXStatus),
        .sendPacketWEn(sendPacketWEn), .sendPacketPID(sendPacketPID), .sendPacketRdy(sendPacketRdy),
        .endPointSel(endPointSel), .EPEnable(EPEnable), .EPReady(EPReady),
        .EPStall(EPStall), .EPDataSeq(EPDataSeq), .transDone(transDone),
        .clrEPRdy(clrEPRdy), .toggleDataSeq(toggleDataSeq), .transType(transType)
    );

    logic ep_en [4];
    logic ep_rdy [4];
    logic ep_stall [4];
    logic ep_seq [4];
    assign EPEnable  = ep_en[endPointSel];
    assign EPReady   = ep_rdy[endPointSel];
    assign EPStall   = ep_stall[endPointSel];
    assign EPDataSeq = ep_seq[endPointSel];

    typedef struct packed {
        logic [3:0] pid;
        logic [6:0] addr;
        logic [3:0] endp;
        logic [7:0] status;
    } pkt_t;

    typedef struct packed {
        logic [3:0] tpid;
        logic [6:0] addr;
        logic [3:0] endp;
        logic [7:0] tstat;
        logic [3:0] dpid;
        logic [7:0] dstat;
    } trans_t;

    typedef struct packed {
        logic [1:0] ttype;
        logic [1:0] ep;
        logic       tog;
    } done_t;

    pkt_t       rx_q[$];
    logic [3:0] exp_tx[$];
    done_t      exp_done[$];
    int         rx_reqs = 0;
    int         n_done = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Receiver: each request delivers the next queued packet, or a time-out.
    initial begin
        pkt_t p;
        getPacketRdy = 1'b1;
        {RXPacketPID, RXAddr, RXEndP, RXStatus} = '0;
        forever begin
            @(negedge clk);
            if (rst && getPacketREn) begin
                rx_reqs++;
                getPacketRdy = 1'b0;
                if (rx_q.size() > 0) p = rx_q.pop_front();
                else p = '{pid: 4'h0, addr: 7'h0, endp: 4'h0, status: 8'h08};
                repeat (3) @(negedge clk);
                {RXPacketPID, RXAddr, RXEndP, RXStatus} = p;
                getPacketRdy = 1'b1;
            end
        end
    end

    // Transmitter: busy for three cycles after each start pulse.
    initial begin
        sendPacketRdy = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && sendPacketWEn) begin
                sendPacketRdy = 1'b0;
                repeat (3) @(negedge clk);
                sendPacketRdy = 1'b1;
            end
        end
    end

    // Compare process: every transmitted PID and completion against the model.
    initial begin
        logic prev_ren, prev_wen, prev_done;
        logic [3:0] tx;
        done_t d;
        prev_ren = 1'b0; prev_wen = 1'b0; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (getPacketREn) check("ren_width", prev_ren, 1'b0);
                if (sendPacketWEn) begin
                    check("wen_width", prev_wen, 1'b0);
                    if (exp_tx.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_tx: got pid %0h, expected no transmission", sendPacketPID);
                    end else begin
                        tx = exp_tx.pop_front();
                        check("tx_pid", sendPacketPID, tx);
                    end
                end
                check("clr_with_done", clrEPRdy, transDone);
                if (transDone) begin
                    n_done++;
                    check("done_width", prev_done, 1'b0);
                    if (exp_done.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_done: got transType %0d, expected no completion", transType);
                    end else begin
                        d = exp_done.pop_front();
                        check("trans_type", transType, d.ttype);
                        check("done_endpoint", endPointSel, d.ep);
                        check("toggle", toggleDataSeq, d.tog);
                    end
                end else begin
                    check("toggle_idle", toggleDataSeq, 1'b0);
                end
            end
            prev_ren = getPacketREn; prev_wen = sendPacketWEn; prev_done = transDone;
        end
    end

    function automatic trans_t mk(input logic [3:0] tpid, input logic [6:0] addr, input logic [3:0] endp,
                                  input logic [7:0] tstat, input logic [3:0] dpid, input logic [7:0] dstat);
        return '{tpid: tpid, addr: addr, endp: endp, tstat: tstat, dpid: dpid, dstat: dstat};
    endfunction

    function automatic logic has_err(input logic [7:0] s);
        return s[SC_CRC_ERROR_BIT] | s[SC_BIT_STUFF_ERROR_BIT] | s[SC_RX_OVERFLOW_BIT] | s[SC_RX_TIME_OUT_BIT];
    endfunction

    // Transaction model: queues what the host must observe; `second` tells
    // whether the device will ask for a data/handshake packet after the token.
    task automatic plan(input trans_t t, output bit second);
        logic [1:0] e;
        second = 1'b0;
        if (has_err(t.tstat) || !(t.tpid inside {PID_IN, PID_OUT, PID_SETUP}) ||
            t.addr != DEV || t.endp >= 4'd4) return;
        e = t.endp[1:0];
        if (!ep_en[e]) return;
        if (t.tpid == PID_IN) begin
            if (ep_stall[e]) exp_tx.push_back(PID_STALL);
            else if (!ep_rdy[e]) exp_tx.push_back(PID_NAK);
            else begin
                exp_tx.push_back(ep_seq[e] ? PID_DATA1 : PID_DATA0);
                second = 1'b1;
                if (t.dpid == PID_ACK && !has_err(t.dstat)) exp_done.push_back('{SC_IN, e, 1'b1});
            end
            return;
        end
        second = 1'b1;
        if (has_err(t.dstat) || !(t.dpid inside {PID_DATA0, PID_DATA1})) return;
        if (t.tpid == PID_SETUP) begin
            exp_tx.push_back(PID_ACK);
            exp_done.push_back('{SC_SETUP, e, !ep_seq[e]});
        end else if (ep_stall[e]) exp_tx.push_back(PID_STALL);
        else if (!ep_rdy[e]) exp_tx.push_back(PID_NAK);
        else if ((t.dpid == PID_DATA1) != ep_seq[e]) exp_tx.push_back(PID_ACK);
        else begin
            exp_tx.push_back(PID_ACK);
            exp_done.push_back('{(t.dpid == PID_DATA1) ? SC_OUTDATA1 : SC_OUTDATA0, e, 1'b1});
        end
    endtask

    task automatic drain();
        int i = 0;
        while (rx_q.size() != 0 && i < 400) begin
            @(negedge clk); #1;
            i++;
        end
        check("drain_rx_queue", rx_q.size(), 0);
    endtask

    task automatic execute(input trans_t t, input bit second);
        rx_q.push_back('{pid: t.tpid, addr: t.addr, endp: t.endp, status: t.tstat});
        if (second) rx_q.push_back('{pid: t.dpid, addr: 7'h0, endp: 4'h0, status: t.dstat});
        drain();
        repeat (30) @(negedge clk);
        check("tx_outstanding", exp_tx.size(), 0);
        check("done_outstanding", exp_done.size(), 0);
    endtask

    task automatic txn(input logic [3:0] tpid, input logic [6:0] addr, input logic [3:0] endp,
                       input logic [7:0] tstat, input logic [3:0] dpid, input logic [7:0] dstat);
        trans_t t;
        bit s;
        t = mk(tpid, addr, endp, tstat, dpid, dstat);
        plan(t, s);
        execute(t, s);
    endtask

    task automatic set_ep(input int e, input logic en, input logic rdy, input logic stall, input logic seq);
        ep_en[e] = en; ep_rdy[e] = rdy; ep_stall[e] = stall; ep_seq[e] = seq;
    endtask

    initial begin
        trans_t t;
        bit s;
        int r;
        for (int i = 0; i < 4; i++) set_ep(i, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {getPacketREn, sendPacketWEn, sendPacketPID, endPointSel,
                                transDone, clrEPRdy, toggleDataSeq, transType}, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_no_request", rx_reqs, 0);
        SCGlobalEn = 1'b1;
        repeat (10) @(negedge clk);

        // IN with data ready, DATA1 expected, host ACKs.
        set_ep(1, 1'b1, 1'b1, 1'b0, 1'b1);
        t = mk(PID_IN, DEV, 4'd1, 8'h00, PID_ACK, 8'h00);
        plan(t, s);
        check("model_in_data1", exp_tx[0], PID_DATA1);
        check("model_in_done", {exp_done[0].ttype, exp_done[0].ep}, {SC_IN, 2'd1});
        execute(t, s);

        // IN NAK, then STALL, then data with host NAK / corrupted ACK.
        set_ep(2, 1'b1, 1'b0, 1'b0, 1'b0);
        t = mk(PID_IN, DEV, 4'd2, 8'h00, PID_ACK, 8'h00);
        plan(t, s);
        check("model_in_nak", exp_tx[0], PID_NAK);
        execute(t, s);
        set_ep(2, 1'b1, 1'b0, 1'b1, 1'b0);
        txn(PID_IN, DEV, 4'd2, 8'h00, PID_ACK, 8'h00);
        set_ep(2, 1'b1, 1'b1, 1'b0, 1'b0);
        txn(PID_IN, DEV, 4'd2, 8'h00, PID_NAK, 8'h00);
        txn(PID_IN, DEV, 4'd2, 8'h00, PID_ACK, 8'h01);

        // OUT DATA0 in sequence, then duplicate, then DATA1, NAK, STALL, bad data.
        set_ep(0, 1'b1, 1'b1, 1'b0, 1'b0);
        t = mk(PID_OUT, DEV, 4'd0, 8'h00, PID_DATA0, 8'h00);
        plan(t, s);
        check("model_out_done", exp_done[0].ttype, SC_OUTDATA0);
        execute(t, s);
        set_ep(0, 1'b1, 1'b1, 1'b0, 1'b1);
        txn(PID_OUT, DEV, 4'd0, 8'h00, PID_DATA0, 8'h00);
        txn(PID_OUT, DEV, 4'd0, 8'h00, PID_DATA1, 8'h00);
        set_ep(0, 1'b1, 1'b0, 1'b0, 1'b0);
        txn(PID_OUT, DEV, 4'd0, 8'h00, PID_DATA0, 8'h00);
        set_ep(0, 1'b1, 1'b1, 1'b1, 1'b0);
        txn(PID_OUT, DEV, 4'd0, 8'h00, PID_DATA0, 8'h00);
        set_ep(0, 1'b1, 1'b1, 1'b0, 1'b0);
        txn(PID_OUT, DEV, 4'd0, 8'h00, PID_DATA0, 8'h02);
        txn(PID_OUT, DEV, 4'd0, 8'h00, PID_ACK, 8'h00);

        // SETUP to stalled, not-ready endpoint, with both toggle states.
        set_ep(0, 1'b1, 1'b0, 1'b1, 1'b0);
        t = mk(PID_SETUP, DEV, 4'd0, 8'h00, PID_DATA0, 8'h00);
        plan(t, s);
        check("model_setup", {exp_tx[0], exp_done[0].ttype, exp_done[0].tog}, {PID_ACK, SC_SETUP, 1'b1});
        execute(t, s);
        set_ep(0, 1'b1, 1'b0, 1'b1, 1'b1);
        txn(PID_SETUP, DEV, 4'd0, 8'h00, PID_DATA0, 8'h00);

        // Tokens that must be ignored; a fresh request must follow each.
        set_ep(3, 1'b0, 1'b1, 1'b0, 1'b0);
        r = rx_reqs;
        txn(PID_IN, 7'd3, 4'd1, 8'h00, PID_ACK, 8'h00);
        check("new_req_after_addr", rx_reqs > r + 1, 1'b1);
        r = rx_reqs;
        txn(PID_IN, DEV, 4'd1, 8'h01, PID_ACK, 8'h00);
        check("new_req_after_crc", rx_reqs > r + 1, 1'b1);
        r = rx_reqs;
        txn(PID_IN, DEV, 4'd5, 8'h00, PID_ACK, 8'h00);
        check("new_req_after_endp", rx_reqs > r + 1, 1'b1);
        txn(PID_OUT, DEV, 4'd3, 8'h00, PID_DATA0, 8'h00);
        txn(PID_ACK, DEV, 4'd1, 8'h00, PID_ACK, 8'h00);

        // Disabling the slave stops packet requests; re-enabling resumes them.
        SCGlobalEn = 1'b0;
        repeat (20) @(negedge clk);
        r = rx_reqs;
        repeat (20) @(negedge clk);
        check("disabled_no_request", rx_reqs, r);
        SCGlobalEn = 1'b1;
        repeat (20) @(negedge clk);
        check("reenabled_request", rx_reqs > r, 1'b1);

        // Asynchronous reset while waiting for the host ACK of an IN.
        set_ep(1, 1'b1, 1'b1, 1'b0, 1'b0);
        t = mk(PID_IN, DEV, 4'd1, 8'h00, PID_ACK, 8'h00);
        plan(t, s);
        exp_done.delete();
        rx_q.push_back('{pid: t.tpid, addr: t.addr, endp: t.endp, status: t.tstat});
        rx_q.push_back('{pid: t.dpid, addr: 7'h0, endp: 4'h0, status: t.dstat});
        drain();
        #1 rst = 1'b0;
        #1 check("async_reset_outputs", {getPacketREn, sendPacketWEn, sendPacketPID, endPointSel,
                                          transDone, clrEPRdy, toggleDataSeq, transType}, 0);
        r = n_done;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("no_done_after_reset", n_done, r);
        check("tx_after_reset", exp_tx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 500000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
